// File: rtl/sr_muldiv.sv
// Iterative RV32M multiply/divide unit with a start/busy/valid handshake.
// Magnitude shift-add multiply and restoring divide; divide-by-zero and overflow bypass CALC.
module sr_muldiv #(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       oper,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] result
);

   // state  | meaning
   // S_IDLE | waiting for start; result held
   // S_CALC | UNROLL bits of multiply/divide per cycle, N cycles
   // S_FIX  | sign correction and half/quotient/remainder select
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   localparam int N  = WIDTH / UNROLL;
   localparam int CW = $clog2(N + 1);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [2:0]       op_q;
   logic             neg_q, sa_q, special_q;
   logic [WIDTH-1:0] hi, lo, bm;

   logic             a_sgn, b_sgn, div_zero, ovf, special;
   logic [WIDTH-1:0] a_abs, b_abs, spec_val;
   logic [WIDTH-1:0] step_hi, step_lo, fix_val;
   logic [2*WIDTH-1:0] prod_s;

   // Operand decode at the accepting edge
   always_comb begin
      a_sgn    = srcA[WIDTH-1] & (oper == OP_MULH || oper == OP_MULHSU ||
                                  oper == OP_DIV  || oper == OP_REM);
      b_sgn    = srcB[WIDTH-1] & (oper == OP_MULH || oper == OP_DIV || oper == OP_REM);
      a_abs    = a_sgn ? -srcA : srcA;
      b_abs    = b_sgn ? -srcB : srcB;
      div_zero = (srcB == '0);
      ovf      = (oper == OP_DIV || oper == OP_REM) &&
                 (srcA == {1'b1, {(WIDTH-1){1'b0}}}) && (srcB == '1);
      special  = oper[2] & (div_zero | ovf);
      if (!oper[1])
         spec_val = div_zero ? '1 : srcA;
      else
         spec_val = div_zero ? srcA : '0;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = special ? S_FIX : S_CALC;
         S_CALC:  if (cnt == '0) state_nx = S_FIX;
         S_FIX:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

   // hi/lo: product accumulator for multiply, remainder/quotient for divide
   always_comb begin
      logic [WIDTH-1:0] h, l;
      logic [WIDTH:0]   rs, df, sm;
      h  = hi;
      l  = lo;
      rs = '0;
      df = '0;
      sm = '0;
      for (int i = 0; i < UNROLL; i++) begin
         if (op_q[2]) begin
            rs = {h, l[WIDTH-1]};
            df = rs - {1'b0, bm};
            if (!df[WIDTH]) begin
               h = df[WIDTH-1:0];
               l = {l[WIDTH-2:0], 1'b1};
            end else begin
               h = rs[WIDTH-1:0];
               l = {l[WIDTH-2:0], 1'b0};
            end
         end else begin
            sm = {1'b0, h} + (l[0] ? {1'b0, bm} : '0);
            h  = sm[WIDTH:1];
            l  = {sm[0], l[WIDTH-1:1]};
         end
      end
      step_hi = h;
      step_lo = l;
   end

   always_comb begin
      prod_s = neg_q ? -{hi, lo} : {hi, lo};
      if (special_q)
         fix_val = hi;
      else begin
         case (op_q)
            3'b000:                 fix_val = prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_val = neg_q ? -lo : lo;
            default:                fix_val = sa_q ? -hi : hi;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         valid     <= 1'b0;
         result    <= '0;
         cnt       <= '0;
         op_q      <= OP_MUL;
         neg_q     <= 1'b0;
         sa_q      <= 1'b0;
         special_q <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         bm        <= '0;
      end else begin
         state <= state_nx;
         valid <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               op_q      <= oper;
               neg_q     <= a_sgn ^ b_sgn;
               sa_q      <= a_sgn;
               special_q <= special;
               hi        <= special ? spec_val : '0;
               lo        <= a_abs;
               bm        <= b_abs;
               cnt       <= CW'(N - 1);
            end
            S_CALC: begin
               hi <= step_hi;
               lo <= step_lo;
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            S_FIX: begin
               result <= fix_val;
               valid  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
